global_buffer_sequencer: RTL and testbench
==========================================

Name: global_buffer_sequencer

Overview:
- Initiator for the global buffer instruction port: drives the instruction bus and consumes the buffer's ready.
- Expands one start command with four counts (M weights, N activations, O outputs, P reads) into the full legal stream: LOAD_WEIGHT×M, LOAD_ACTIVATION×N, POINTER_RESET, LOAD_OUTPUT×O, POINTER_RESET, READ_ACTIVATION×P.
- Handshakes the external write source and the OBUF write source; counts read-data returns before reporting done.

Parameters:
- depth, 1024, global buffer depth in words.
- addrWidth, $clog2(depth), buffer address width.
- cntWidth, addrWidth+1, width of count inputs and counters; a count equal to depth must be representable.

Ports:
- clk  input  1  clock; single clock domain.
- nrst  input  1  reset, synchronous, active-low.
- start_i  input  1  command strobe; accepted only in IDLE.
- weight_count_i  input  cntWidth  M, latched on accepted start.
- act_count_i  input  cntWidth  N, latched on accepted start.
- out_count_i  input  cntWidth  O, latched on accepted start.
- read_count_i  input  cntWidth  P, latched on accepted start.
- inst_o  output  global_buffer_instruction_t  instruction to buffer inst_i.
- gbuf_ready_i  input  1  buffer ready_o.
- gbuf_rd_valid_i  input  1  buffer read-data valid, one pulse per returned word.
- ext_wr_valid_i  input  1  external write data available.
- ext_wr_ready_o  output  1  external word consumed this cycle.
- obuf_wr_valid_i  input  1  OBUF write data available.
- obuf_wr_ready_o  output  1  OBUF word consumed this cycle.
- busy_o  output  1  high outside IDLE.
- done_o  output  1  one-cycle pulse on completion.

Behaviour:
- Reset: synchronous on clk when nrst=0.
  - State is IDLE; all counters are 0.
  - Outputs: inst_o=I_NOP; ext_wr_ready_o, obuf_wr_ready_o, busy_o, done_o all 0.
  - Reset mid-operation abandons the command immediately. No POINTER_RESET is emitted.
- States: IDLE, LOAD_W, LOAD_A, PRST1, LOAD_O, PRST2, READ_A, DRAIN, DONE.
- Issue rule:
  - inst_o is combinational from state and gates.
  - inst_o is non-NOP only when gbuf_ready_i=1 and the phase's data gate holds.
  - An instruction is issued in any cycle where inst_o≠I_NOP. The buffer advances its pointers on every non-NOP, so no issue is ever presented while ready is low.
- Data gates:
  - LOAD_W and LOAD_A require ext_wr_valid_i; ext_wr_ready_o = issue in those states.
  - LOAD_O requires obuf_wr_valid_i; obuf_wr_ready_o = issue in LOAD_O.
  - PRST and READ_A have no data gate.
- Counting: the issue counter increments per issue and clears on phase exit. A phase exits on the cycle its issue count reaches its latched count, so the next state's first issue is no earlier than the following cycle.
- Transitions:
  - IDLE → LOAD_W on start_i. All four counts are latched.
  - Phases with count 0 are skipped in the same transition, e.g. M=0 goes IDLE→LOAD_A. PRST1 and PRST2 are never skipped.
  - PRST1 issues one I_POINTER_RESET, then goes to LOAD_O.
  - PRST2 issues one I_POINTER_RESET, then goes to READ_A.
  - READ_A → DRAIN after P issues.
  - DRAIN → DONE when the returned-valid count equals P.
  - DONE → IDLE after one cycle, with done_o=1 in that cycle.
  - All counts 0: IDLE, PRST1, PRST2, DRAIN, DONE. Two pointer resets are emitted.
- Read-return counter: counts gbuf_rd_valid_i in READ_A and DRAIN. Returns in READ_A are counted alongside issues in the same cycle. Valid pulses in any other state are ignored.
- Simultaneous start_i and done cycle: start is ignored; it is accepted only in IDLE.
- Counter arithmetic is unsigned cntWidth. Counts greater than depth are not checked.

Optional Feature:
- Macro GBUF_SEQ_PERF_EN.
- Defined:
  - Adds output stall_cycles_o, 32 bits.
  - Counts cycles where busy_o=1 and no instruction issued, DRAIN excluded.
  - Clears on accepted start and on reset; saturates at all-ones; holds after DONE.
- Undefined: the port and counter are absent. No other behaviour changes.

Test Plan:
- Basic stream: M=2, N=3, O=1, P=2, all valids and ready tied 1.
  - Expect inst_o sequence W,W,A,A,A,PRST,O,PRST,R,R, one per cycle.
  - Buffer model returns 2 valids; done_o pulses once; busy_o then falls.
- Ready stall: P=4 with gbuf_ready_i low 2 cycles after each read.
  - inst_o is I_NOP whenever ready=0; exactly 4 READ_ACTIVATION issues.
- Data stall: N=3 with ext_wr_valid_i toggled 1,0,0,1,1.
  - ext_wr_ready_o is high only on valid&ready cycles; exactly 3 LOAD_ACTIVATION issues.
- Zero counts: M=O=P=0, N=1.
  - Sequence A,PRST,PRST; done 1 cycle after DRAIN.
- Reset mid-LOAD_O (after 1 of 3 issues): nrst low 1 cycle.
  - Next cycle: inst_o=I_NOP, busy_o=0; a fresh start runs a full stream correctly.
- Start ignored: start_i pulsed during LOAD_W with different counts.
  - Original counts are honoured; exactly one done_o.

Source files
------------

// File: rtl/global_buffer_sequencer.sv
// ---------------------------------------------------------------------------
// global_buffer_sequencer
//
// Purpose:
//   Initiator for the global buffer instruction port. One start command with
//   four counts (M weights, N activations, O outputs, P reads) is expanded
//   into the stream
//      LOAD_WEIGHT x M, LOAD_ACTIVATION x N, POINTER_RESET,
//      LOAD_OUTPUT x O, POINTER_RESET, READ_ACTIVATION x P
//   after which read-data returns are counted until all P words are back,
//   and done_o pulses for one cycle.
//
// Ports:
//   clk              clock (single domain)
//   nrst             synchronous active-low reset
//   start_i          command strobe, accepted only while idle
//   weight_count_i   M, latched on accepted start
//   act_count_i      N, latched on accepted start
//   out_count_i      O, latched on accepted start
//   read_count_i     P, latched on accepted start
//   inst_o           instruction to the buffer (I_NOP when nothing issues)
//   gbuf_ready_i     buffer ready
//   gbuf_rd_valid_i  buffer read-data valid, one pulse per returned word
//   ext_wr_valid_i   external write data available
//   ext_wr_ready_o   external word consumed this cycle
//   obuf_wr_valid_i  OBUF write data available
//   obuf_wr_ready_o  OBUF word consumed this cycle
//   stall_cycles_o   (GBUF_SEQ_PERF_EN only) busy cycles with no issue,
//                    drain excluded, saturating 32-bit counter
//   busy_o           high outside idle
//   done_o           one-cycle completion pulse
//
// Optional feature macro: GBUF_SEQ_PERF_EN
// ---------------------------------------------------------------------------

package global_buffer_pkg;

    typedef enum logic [2:0] {
        I_NOP             = 3'd0,
        I_LOAD_WEIGHT     = 3'd1,
        I_LOAD_ACTIVATION = 3'd2,
        I_LOAD_OUTPUT     = 3'd3,
        I_READ_ACTIVATION = 3'd4,
        I_POINTER_RESET   = 3'd5
    } global_buffer_instruction_t;

endpackage

module global_buffer_sequencer
    import global_buffer_pkg::*;
#(
    parameter int depth     = 1024,
    parameter int addrWidth = $clog2(depth),
    parameter int cntWidth  = addrWidth + 1
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       start_i,
    input  logic [cntWidth-1:0]        weight_count_i,
    input  logic [cntWidth-1:0]        act_count_i,
    input  logic [cntWidth-1:0]        out_count_i,
    input  logic [cntWidth-1:0]        read_count_i,
    output global_buffer_instruction_t inst_o,
    input  logic                       gbuf_ready_i,
    input  logic                       gbuf_rd_valid_i,
    input  logic                       ext_wr_valid_i,
    output logic                       ext_wr_ready_o,
    input  logic                       obuf_wr_valid_i,
    output logic                       obuf_wr_ready_o,
`ifdef GBUF_SEQ_PERF_EN
    output logic [31:0]                stall_cycles_o,
`endif
    output logic                       busy_o,
    output logic                       done_o
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LOAD_W = 4'd1,
        ST_LOAD_A = 4'd2,
        ST_PRST1  = 4'd3,
        ST_LOAD_O = 4'd4,
        ST_PRST2  = 4'd5,
        ST_READ_A = 4'd6,
        ST_DRAIN  = 4'd7,
        ST_DONE   = 4'd8
    } state_t;

    state_t                     state;
    state_t                     next_state;

    logic [cntWidth-1:0]        weight_cnt_q;
    logic [cntWidth-1:0]        act_cnt_q;
    logic [cntWidth-1:0]        out_cnt_q;
    logic [cntWidth-1:0]        read_cnt_q;

    logic [cntWidth-1:0]        issue_cnt;
    logic [cntWidth-1:0]        issue_cnt_inc;
    logic [cntWidth-1:0]        rd_return_cnt;
    logic [cntWidth-1:0]        phase_count;

    global_buffer_instruction_t phase_inst;
    logic                       data_gate;
    logic                       issue;
    logic                       phase_last;
    logic                       accept_start;

    assign accept_start  = (state == ST_IDLE) && start_i;
    assign issue_cnt_inc = issue_cnt + cntWidth'(1);

    // Per-state instruction and data gate. An instruction is only presented
    // when the buffer is ready and the phase's data source has a word, since
    // the buffer advances its pointers on every non-NOP it sees.
    always_comb begin
        phase_inst  = I_NOP;
        data_gate   = 1'b0;
        phase_count = '0;
        unique case (state)
            ST_LOAD_W: begin
                phase_inst  = I_LOAD_WEIGHT;
                data_gate   = ext_wr_valid_i;
                phase_count = weight_cnt_q;
            end
            ST_LOAD_A: begin
                phase_inst  = I_LOAD_ACTIVATION;
                data_gate   = ext_wr_valid_i;
                phase_count = act_cnt_q;
            end
            ST_PRST1, ST_PRST2: begin
                phase_inst  = I_POINTER_RESET;
                data_gate   = 1'b1;
                phase_count = cntWidth'(1);
            end
            ST_LOAD_O: begin
                phase_inst  = I_LOAD_OUTPUT;
                data_gate   = obuf_wr_valid_i;
                phase_count = out_cnt_q;
            end
            ST_READ_A: begin
                phase_inst  = I_READ_ACTIVATION;
                data_gate   = 1'b1;
                phase_count = read_cnt_q;
            end
            default: begin
                phase_inst  = I_NOP;
                data_gate   = 1'b0;
                phase_count = '0;
            end
        endcase
    end

    // Issue decode and the data-source handshakes that follow from it.
    always_comb begin
        issue           = gbuf_ready_i && data_gate && (phase_inst != I_NOP);
        inst_o          = issue ? phase_inst : I_NOP;
        ext_wr_ready_o  = issue && ((state == ST_LOAD_W) || (state == ST_LOAD_A));
        obuf_wr_ready_o = issue && (state == ST_LOAD_O);
        phase_last      = issue && (issue_cnt_inc == phase_count);
        busy_o          = (state != ST_IDLE);
        done_o          = (state == ST_DONE);
    end

    // Next-state logic. Phases with a zero count are skipped within the same
    // transition; the two pointer resets are always visited. From idle the
    // skip decision uses the live count inputs since they are latched only on
    // this edge.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (start_i) begin
                    if (weight_count_i != '0) begin
                        next_state = ST_LOAD_W;
                    end else if (act_count_i != '0) begin
                        next_state = ST_LOAD_A;
                    end else begin
                        next_state = ST_PRST1;
                    end
                end
            end
            ST_LOAD_W: begin
                if (phase_last) begin
                    next_state = (act_cnt_q != '0) ? ST_LOAD_A : ST_PRST1;
                end
            end
            ST_LOAD_A: begin
                if (phase_last) begin
                    next_state = ST_PRST1;
                end
            end
            ST_PRST1: begin
                if (phase_last) begin
                    next_state = (out_cnt_q != '0) ? ST_LOAD_O : ST_PRST2;
                end
            end
            ST_LOAD_O: begin
                if (phase_last) begin
                    next_state = ST_PRST2;
                end
            end
            ST_PRST2: begin
                if (phase_last) begin
                    next_state = (read_cnt_q != '0) ? ST_READ_A : ST_DRAIN;
                end
            end
            ST_READ_A: begin
                if (phase_last) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (rd_return_cnt == read_cnt_q) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State register. Reset abandons any command in flight.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Command counts, captured only when a start is accepted in idle.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            weight_cnt_q <= '0;
            act_cnt_q    <= '0;
            out_cnt_q    <= '0;
            read_cnt_q   <= '0;
        end else if (accept_start) begin
            weight_cnt_q <= weight_count_i;
            act_cnt_q    <= act_count_i;
            out_cnt_q    <= out_count_i;
            read_cnt_q   <= read_count_i;
        end
    end

    // Per-phase issue counter; cleared on the phase's final issue so the
    // next phase starts from zero.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            issue_cnt <= '0;
        end else if (accept_start || phase_last) begin
            issue_cnt <= '0;
        end else if (issue) begin
            issue_cnt <= issue_cnt_inc;
        end
    end

    // Read-return counter. Returns can overlap the read phase itself, so
    // valids are counted in both READ_A and DRAIN and ignored elsewhere.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            rd_return_cnt <= '0;
        end else if (accept_start) begin
            rd_return_cnt <= '0;
        end else if (gbuf_rd_valid_i &&
                     ((state == ST_READ_A) || (state == ST_DRAIN))) begin
            rd_return_cnt <= rd_return_cnt + cntWidth'(1);
        end
    end

`ifdef GBUF_SEQ_PERF_EN
    logic [31:0] stall_cnt;

    // Stall counter: busy cycles without an issue, drain excluded. It
    // saturates and keeps its value after completion until the next start.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            stall_cnt <= '0;
        end else if (accept_start) begin
            stall_cnt <= '0;
        end else if (busy_o && !issue && (state != ST_DRAIN) &&
                     (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles_o = stall_cnt;
`endif

endmodule

// File: tb/tb_global_buffer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_global_buffer_sequencer
//
// Purpose:
//   Self-checking bench for global_buffer_sequencer. A per-cycle vector
//   table covers the basic stream; hand-written sequences cover ready and
//   data stalls, zero counts, reset mid-command and ignored starts.
// ---------------------------------------------------------------------------

module tb_global_buffer_sequencer;
    import global_buffer_pkg::*;

    localparam int CNT_W = 11;

    logic                       clk;
    logic                       nrst;
    logic                       start_i;
    logic [CNT_W-1:0]           weight_count_i;
    logic [CNT_W-1:0]           act_count_i;
    logic [CNT_W-1:0]           out_count_i;
    logic [CNT_W-1:0]           read_count_i;
    global_buffer_instruction_t inst_o;
    logic                       gbuf_ready_i;
    logic                       gbuf_rd_valid_i;
    logic                       ext_wr_valid_i;
    logic                       ext_wr_ready_o;
    logic                       obuf_wr_valid_i;
    logic                       obuf_wr_ready_o;
    logic                       busy_o;
    logic                       done_o;
`ifdef GBUF_SEQ_PERF_EN
    logic [31:0]                stall_cycles;
`endif

    int checks;
    int errors;

    global_buffer_instruction_t trace_q[$];
    global_buffer_instruction_t exp_q[$];
    int                         done_count;
    int                         done_cycle;

    typedef struct {
        logic                       start;
        logic                       rd_valid;
        global_buffer_instruction_t inst;
        logic                       ext_rdy;
        logic                       obuf_rdy;
        logic                       busy;
        logic                       done;
    } vec_t;

    vec_t tbl[15];

    global_buffer_sequencer dut (
        .clk             (clk),
        .nrst            (nrst),
        .start_i         (start_i),
        .weight_count_i  (weight_count_i),
        .act_count_i     (act_count_i),
        .out_count_i     (out_count_i),
        .read_count_i    (read_count_i),
        .inst_o          (inst_o),
        .gbuf_ready_i    (gbuf_ready_i),
        .gbuf_rd_valid_i (gbuf_rd_valid_i),
        .ext_wr_valid_i  (ext_wr_valid_i),
        .ext_wr_ready_o  (ext_wr_ready_o),
        .obuf_wr_valid_i (obuf_wr_valid_i),
        .obuf_wr_ready_o (obuf_wr_ready_o),
`ifdef GBUF_SEQ_PERF_EN
        .stall_cycles_o  (stall_cycles),
`endif
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drives one table row's inputs (counts fixed at M=2 N=3 O=1 P=2).
    task automatic applyStimulus(input vec_t v);
        start_i         = v.start;
        gbuf_rd_valid_i = v.rd_valid;
        gbuf_ready_i    = 1'b1;
        ext_wr_valid_i  = 1'b1;
        obuf_wr_valid_i = 1'b1;
        weight_count_i  = CNT_W'(2);
        act_count_i     = CNT_W'(3);
        out_count_i     = CNT_W'(1);
        read_count_i    = CNT_W'(2);
    endtask

    // Compares the recorded issue trace against exp_q.
    task automatic compareTrace(input string name);
        checkOutput({name, "_issue_count"}, trace_q.size(), exp_q.size());
        for (int i = 0; i < trace_q.size() && i < exp_q.size(); i++) begin
            checkOutput($sformatf("%s_issue%0d", name, i), int'(trace_q[i]), int'(exp_q[i]));
        end
    endtask

    // Runs one command to completion with a small buffer model that returns
    // a read word the cycle after each READ_ACTIVATION. Optional ready stall
    // after each read, optional ext-valid pattern on cycles 1..5, optional
    // second start with different counts on cycle 1.
    task automatic runStream(input string name, input int m, input int n, input int o,
                             input int p, input bit stall_reads, input bit use_pattern,
                             input logic [4:0] pattern, input bit restart);
        int  stall_left;
        bit  last_r;
        bit  seen;
        stall_left = 0;
        last_r     = 1'b0;
        seen       = 1'b0;
        trace_q.delete();
        done_count = 0;
        done_cycle = -1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            start_i = (c == 0) || (restart && (c == 1));
            if (c == 0) begin
                weight_count_i = CNT_W'(m);
                act_count_i    = CNT_W'(n);
                out_count_i    = CNT_W'(o);
                read_count_i   = CNT_W'(p);
            end else if (restart && (c == 1)) begin
                weight_count_i = CNT_W'(5);
                act_count_i    = CNT_W'(5);
                out_count_i    = CNT_W'(5);
                read_count_i   = CNT_W'(5);
            end
            gbuf_ready_i    = stall_reads ? (stall_left == 0) : 1'b1;
            ext_wr_valid_i  = use_pattern ? ((c >= 1 && c <= 5) ? pattern[c-1] : 1'b0) : 1'b1;
            obuf_wr_valid_i = 1'b1;
            gbuf_rd_valid_i = last_r;
            #1;
            if (seen) begin
                checkOutput({name, "_busy_after_done"}, int'(busy_o), 0);
                break;
            end
            if (!gbuf_ready_i) begin
                checkOutput({name, "_nop_when_not_ready"}, int'(inst_o), int'(I_NOP));
            end
            if (use_pattern && c >= 1 && c <= 5) begin
                checkOutput($sformatf("%s_ext_ready_c%0d", name, c),
                            int'(ext_wr_ready_o), int'(pattern[c-1]));
            end
            if (inst_o != I_NOP) begin
                trace_q.push_back(inst_o);
            end
            if (done_o) begin
                done_count++;
                done_cycle = c;
                seen       = 1'b1;
            end
            last_r = (inst_o == I_READ_ACTIVATION);
            if (stall_reads) begin
                if (last_r) begin
                    stall_left = 2;
                end else if (stall_left > 0) begin
                    stall_left--;
                end
            end
        end
        start_i = 1'b0;
        checkOutput({name, "_done_count"}, done_count, 1);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        nrst            = 1'b0;
        start_i         = 1'b0;
        weight_count_i  = '0;
        act_count_i     = '0;
        out_count_i     = '0;
        read_count_i    = '0;
        gbuf_ready_i    = 1'b1;
        gbuf_rd_valid_i = 1'b0;
        ext_wr_valid_i  = 1'b1;
        obuf_wr_valid_i = 1'b1;

        // Basic stream M=2 N=3 O=1 P=2; read returns one cycle after each read.
        tbl[0]  = '{1'b1, 1'b0, I_NOP,             1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, I_LOAD_WEIGHT,     1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, I_LOAD_WEIGHT,     1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, I_LOAD_ACTIVATION, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, I_LOAD_ACTIVATION, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, I_LOAD_ACTIVATION, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, I_POINTER_RESET,   1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, I_LOAD_OUTPUT,     1'b0, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, I_POINTER_RESET,   1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, I_READ_ACTIVATION, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, I_READ_ACTIVATION, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, I_NOP,             1'b0, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, I_NOP,             1'b0, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, I_NOP,             1'b0, 1'b0, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 1'b0, I_NOP,             1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state, with every valid and ready high so nothing is masked.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset_inst", int'(inst_o), int'(I_NOP));
        checkOutput("reset_ext_ready", int'(ext_wr_ready_o), 0);
        checkOutput("reset_obuf_ready", int'(obuf_wr_ready_o), 0);
        checkOutput("reset_busy", int'(busy_o), 0);
        checkOutput("reset_done", int'(done_o), 0);
        @(negedge clk);
        nrst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            applyStimulus(tbl[i]);
            #1;
            checkOutput($sformatf("basic_inst_c%0d", i), int'(inst_o), int'(tbl[i].inst));
            checkOutput($sformatf("basic_ext_ready_c%0d", i), int'(ext_wr_ready_o), int'(tbl[i].ext_rdy));
            checkOutput($sformatf("basic_obuf_ready_c%0d", i), int'(obuf_wr_ready_o), int'(tbl[i].obuf_rdy));
            checkOutput($sformatf("basic_busy_c%0d", i), int'(busy_o), int'(tbl[i].busy));
            checkOutput($sformatf("basic_done_c%0d", i), int'(done_o), int'(tbl[i].done));
        end
        gbuf_rd_valid_i = 1'b0;

        // Ready stall: P=4, ready low for two cycles after each read.
        runStream("ready_stall", 0, 0, 0, 4, 1'b1, 1'b0, 5'b00000, 1'b0);
        exp_q = '{I_POINTER_RESET, I_POINTER_RESET, I_READ_ACTIVATION,
                  I_READ_ACTIVATION, I_READ_ACTIVATION, I_READ_ACTIVATION};
        compareTrace("ready_stall");

        // Data stall: N=3, ext valid 1,0,0,1,1 across the activation phase.
        runStream("data_stall", 0, 3, 0, 0, 1'b0, 1'b1, 5'b11001, 1'b0);
        exp_q = '{I_LOAD_ACTIVATION, I_LOAD_ACTIVATION, I_LOAD_ACTIVATION,
                  I_POINTER_RESET, I_POINTER_RESET};
        compareTrace("data_stall");

        // Zero counts except N=1: A, PRST, PRST, one drain cycle, then done.
        runStream("zero_counts", 0, 1, 0, 0, 1'b0, 1'b0, 5'b00000, 1'b0);
        exp_q = '{I_LOAD_ACTIVATION, I_POINTER_RESET, I_POINTER_RESET};
        compareTrace("zero_counts");
        checkOutput("zero_counts_done_cycle", done_cycle, 5);

        // Start pulsed again during LOAD_W with other counts must be ignored.
        runStream("start_ignored", 2, 1, 1, 1, 1'b0, 1'b0, 5'b00000, 1'b1);
        exp_q = '{I_LOAD_WEIGHT, I_LOAD_WEIGHT, I_LOAD_ACTIVATION, I_POINTER_RESET,
                  I_LOAD_OUTPUT, I_POINTER_RESET, I_READ_ACTIVATION};
        compareTrace("start_ignored");

        // Reset after the first of three LOAD_OUTPUT issues.
        @(negedge clk);
        weight_count_i  = CNT_W'(0);
        act_count_i     = CNT_W'(0);
        out_count_i     = CNT_W'(3);
        read_count_i    = CNT_W'(0);
        gbuf_ready_i    = 1'b1;
        obuf_wr_valid_i = 1'b1;
        ext_wr_valid_i  = 1'b1;
        gbuf_rd_valid_i = 1'b0;
        start_i         = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        #1;
        checkOutput("rst_mid_prst1", int'(inst_o), int'(I_POINTER_RESET));
        @(negedge clk);
        #1;
        checkOutput("rst_mid_first_output", int'(inst_o), int'(I_LOAD_OUTPUT));
        @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        #1;
        checkOutput("rst_mid_inst", int'(inst_o), int'(I_NOP));
        checkOutput("rst_mid_busy", int'(busy_o), 0);
        checkOutput("rst_mid_obuf_ready", int'(obuf_wr_ready_o), 0);

        runStream("after_reset", 1, 1, 1, 1, 1'b0, 1'b0, 5'b00000, 1'b0);
        exp_q = '{I_LOAD_WEIGHT, I_LOAD_ACTIVATION, I_POINTER_RESET,
                  I_LOAD_OUTPUT, I_POINTER_RESET, I_READ_ACTIVATION};
        compareTrace("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
